// File: rtl/svfloat_div_seq.sv
// svfloat_div_seq: sequential IEEE-754 floating-point divider.
//
// The divider accepts one operand pair at a time and returns the quotient
// through a valid/ready handshake. It handles special operands (NaN, inf,
// zero) in one cycle. Normal operands go through a radix-2 restoring
// division of the significands, one quotient bit per cycle, and a single
// round-to-nearest-even step. Subnormal inputs are treated as zero, and
// results that would be subnormal are flushed to zero.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair offered
//   in_ready   divider idle and able to take operands
//   lhs, rhs   dividend and divisor (packed float)
//   out_valid  result available
//   out_ready  consumer accepts result
//   res        quotient lhs/rhs
//   flags      exception flags {NV, DZ, OF, UF, NX}

package svfloat;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } float32;
endpackage

module svfloat_div_seq #(
  parameter type float           = svfloat::float32,
  parameter int  flush_subnormal = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [$bits(float)-1:0] lhs,
  input  logic [$bits(float)-1:0] rhs,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$bits(float)-1:0] res,
  output logic [4:0]              flags
);

  float lhs_f;
  float rhs_f;
  assign lhs_f = lhs;
  assign rhs_f = rhs;

  localparam int EW = $bits(lhs_f.exp);
  localparam int MW = $bits(lhs_f.mant);
  localparam int SW = EW + 2;           // signed exponent width, no wrap
  localparam int QW = MW + 3;           // quotient bits: 1.mant + guard + round
  localparam int RW = MW + 3;           // partial remainder width
  localparam int CW = $clog2(MW + 4);
  localparam logic [CW-1:0]        LAST_ITER = CW'(MW + 2);
  localparam logic signed [SW-1:0] BIAS      = SW'((1 << (EW - 1)) - 1);
  localparam logic signed [SW-1:0] EMAX      = SW'((1 << EW) - 1);
  localparam logic signed [SW-1:0] ZERO_E    = '0;
  localparam logic signed [SW-1:0] ONE_E     = SW'(1);

  typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;

  state_t                state_r, state_s;
  logic                  sign_r;
  logic signed [SW-1:0]  e_r;
  logic [RW-1:0]         rem_r;
  logic [MW:0]           div_r;
  logic [QW-1:0]         q_r;
  logic [CW-1:0]         cnt_r;
  logic [$bits(float)-1:0] res_r;
  logic [4:0]            flags_r;

  // Operand classification; subnormals count as zero.
  logic a_max, b_max, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, a_snan, b_snan;
  logic special_s;
  assign a_max     = &lhs_f.exp;
  assign b_max     = &rhs_f.exp;
  assign a_zero    = (lhs_f.exp == '0) && ((flush_subnormal != 0) || (lhs_f.mant == '0));
  assign b_zero    = (rhs_f.exp == '0) && ((flush_subnormal != 0) || (rhs_f.mant == '0));
  assign a_nan     = a_max && (lhs_f.mant != '0);
  assign b_nan     = b_max && (rhs_f.mant != '0);
  assign a_inf     = a_max && (lhs_f.mant == '0);
  assign b_inf     = b_max && (rhs_f.mant == '0);
  assign a_snan    = a_nan && !lhs_f.mant[MW-1];
  assign b_snan    = b_nan && !rhs_f.mant[MW-1];
  assign special_s = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

  // Special-operand result, resolved at accept time.
  float       spec_f;
  logic [4:0] spec_flags_s;
  always_comb begin
    spec_f       = '0;
    spec_flags_s = 5'b00000;
    spec_f.sign  = lhs_f.sign ^ rhs_f.sign;
    if (a_nan || b_nan) begin
      spec_f.sign     = 1'b0;
      spec_f.exp      = '1;
      spec_f.mant     = {1'b1, {(MW-1){1'b0}}};
      spec_flags_s[4] = a_snan | b_snan;
    end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
      spec_f.sign     = 1'b0;
      spec_f.exp      = '1;
      spec_f.mant     = {1'b1, {(MW-1){1'b0}}};
      spec_flags_s[4] = 1'b1;
    end else if (a_inf) begin
      spec_f.exp      = '1;
    end else if (b_zero) begin
      spec_f.exp      = '1;
      spec_flags_s[3] = 1'b1;
    end else begin
      spec_f.exp      = '0;  // 0/x or finite/inf: signed zero
    end
  end

  // One restoring-division step.
  logic [RW-1:0] rem_diff_s;
  logic          rem_ge_s;
  assign rem_ge_s   = (rem_r >= {2'b00, div_r});
  assign rem_diff_s = rem_r - {2'b00, div_r};

  // Normalize, round to nearest even, and range-check the quotient.
  logic                 norm_s, guard_s, sticky_s, round_up_s, carry_s;
  logic [QW-1:0]        qn_s;
  logic [MW:0]          sum_s;
  logic signed [SW-1:0] e_n_s, e_f_s;
  float                 rnd_f;
  logic [4:0]           rnd_flags_s;
  always_comb begin
    norm_s      = q_r[QW-1];
    qn_s        = norm_s ? q_r : {q_r[QW-2:0], 1'b0};
    e_n_s       = norm_s ? e_r : (e_r - ONE_E);
    guard_s     = qn_s[1];
    sticky_s    = qn_s[0] | (|rem_r);
    round_up_s  = guard_s & (sticky_s | qn_s[2]);
    sum_s       = {1'b0, qn_s[QW-2:2]} + {{MW{1'b0}}, round_up_s};
    carry_s     = sum_s[MW];
    e_f_s       = carry_s ? (e_n_s + ONE_E) : e_n_s;
    rnd_f       = '0;
    rnd_f.sign  = sign_r;
    rnd_flags_s = 5'b00000;
    if (e_f_s >= EMAX) begin
      rnd_f.exp   = '1;
      rnd_flags_s = 5'b00101;
    end else if (e_f_s <= ZERO_E) begin
      rnd_flags_s = 5'b00011;
    end else begin
      rnd_f.exp   = e_f_s[EW-1:0];
      rnd_f.mant  = sum_s[MW-1:0];
      rnd_flags_s = {4'b0000, guard_s | sticky_s};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_s = special_s ? DONE : DIVIDE;
        else          state_s = IDLE;
      end
      DIVIDE: begin
        if (cnt_r == LAST_ITER) state_s = ROUND;
        else                    state_s = DIVIDE;
      end
      ROUND: state_s = DONE;
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath: operand capture, division iterations and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r  <= 1'b0;
      e_r     <= '0;
      rem_r   <= '0;
      div_r   <= '0;
      q_r     <= '0;
      cnt_r   <= '0;
      res_r   <= '0;
      flags_r <= 5'b00000;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            sign_r <= lhs_f.sign ^ rhs_f.sign;
            e_r    <= $signed({2'b00, lhs_f.exp}) - $signed({2'b00, rhs_f.exp}) + BIAS;
            rem_r  <= {2'b01, lhs_f.mant};
            div_r  <= {1'b1, rhs_f.mant};
            q_r    <= '0;
            cnt_r  <= '0;
            if (special_s) begin
              res_r   <= spec_f;
              flags_r <= spec_flags_s;
            end
          end
        end
        DIVIDE: begin
          cnt_r <= cnt_r + CW'(1);
          if (rem_ge_s) begin
            rem_r <= {rem_diff_s[RW-2:0], 1'b0};
            q_r   <= {q_r[QW-2:0], 1'b1};
          end else begin
            rem_r <= {rem_r[RW-2:0], 1'b0};
            q_r   <= {q_r[QW-2:0], 1'b0};
          end
        end
        ROUND: begin
          res_r   <= rnd_f;
          flags_r <= rnd_flags_s;
        end
        default: begin
          res_r <= res_r;  // DONE: hold result for the consumer
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign res       = res_r;
  assign flags     = flags_r;

endmodule

// File: tb/tb_svfloat_div_seq.sv
// Self-checking bench for svfloat_div_seq (float32): a vector table for
// normal and special operands plus hand-written backpressure and
// mid-operation reset sequences.
module tb_svfloat_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] lhs = 32'h0;
  logic [31:0] rhs = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] res;
  logic [4:0]  flags;

  localparam logic [4:0] NV = 5'b10000;
  localparam logic [4:0] DZ = 5'b01000;
  localparam logic [4:0] OF = 5'b00100;
  localparam logic [4:0] UF = 5'b00010;
  localparam logic [4:0] NX = 5'b00001;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  svfloat_div_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .lhs(lhs), .rhs(rhs), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .flags(flags)
  );

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [4:0]  f;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Offer one operand pair, then scramble the inputs to show they are
  // ignored. Returns edges from accept (accept edge = 1) to out_valid.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] r, output logic [4:0] f);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    lhs = a;
    rhs = b;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    lhs = 32'h7F800001;
    rhs = 32'h00000000;
    n = 1;
    while (!out_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    lat = out_valid ? n : -1;
    r = res;
    f = flags;
  endtask

  task automatic finish_op();
    // wait for the handshake edge (out_ready assumed high)
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    logic [31:0] r;
    logic [4:0] f;
    int seen;

    vecs.push_back('{"exact_6_div_3",   32'h40C00000, 32'h40400000, 32'h40000000, 5'b00000, 28});
    vecs.push_back('{"inexact_1_div_3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, NX,       28});
    vecs.push_back('{"inexact_2_div_3", 32'h40000000, 32'h40400000, 32'h3F2AAAAB, NX,       28});
    vecs.push_back('{"neg_6_div_3",     32'hC0C00000, 32'h40400000, 32'hC0000000, 5'b00000, 28});
    vecs.push_back('{"1p5_div_1",       32'h3FC00000, 32'h3F800000, 32'h3FC00000, 5'b00000, 28});
    vecs.push_back('{"overflow",        32'h7F000000, 32'h3E800000, 32'h7F800000, OF | NX,  28});
    vecs.push_back('{"underflow",       32'h00800000, 32'h7F000000, 32'h00000000, UF | NX,  28});
    vecs.push_back('{"div_by_zero",     32'h3F800000, 32'h00000000, 32'h7F800000, DZ,       1});
    vecs.push_back('{"zero_div_zero",   32'h00000000, 32'h00000000, 32'h7FC00000, NV,       1});
    vecs.push_back('{"neg1_div_inf",    32'hBF800000, 32'h7F800000, 32'h80000000, 5'b00000, 1});
    vecs.push_back('{"inf_div_inf",     32'h7F800000, 32'hFF800000, 32'h7FC00000, NV,       1});
    vecs.push_back('{"inf_div_2",       32'h7F800000, 32'hC0000000, 32'hFF800000, 5'b00000, 1});
    vecs.push_back('{"qnan_in",         32'h7FC00000, 32'h3F800000, 32'h7FC00000, 5'b00000, 1});
    vecs.push_back('{"snan_in",         32'h3F800000, 32'h7F800001, 32'h7FC00000, NV,       1});
    vecs.push_back('{"subnorm_lhs",     32'h80000001, 32'h3F800000, 32'h80000000, 5'b00000, 1});

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_res", res, 32'h0);
    chk("rst_flags", {27'b0, flags}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Table-driven vectors.
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, lat, r, f);
      chk({vecs[i].name, "_lat"}, lat, vecs[i].lat);
      chk({vecs[i].name, "_res"}, r, vecs[i].r);
      chk({vecs[i].name, "_flags"}, {27'b0, f}, {27'b0, vecs[i].f});
      finish_op();
    end

    // Backpressure: result held while out_ready is low.
    out_ready = 1'b0;
    run_op(32'h40C00000, 32'h40400000, lat, r, f);
    chk("bp_lat", lat, 28);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_res", res, 32'h40000000);
      chk("bp_flags", {27'b0, flags}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
    chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    chk("bp_res_held_in_idle", res, 32'h40000000);

    // Reset pulse in the middle of DIVIDE.
    @(negedge clk);
    in_valid = 1'b1;
    lhs = 32'h3F800000;
    rhs = 32'h40400000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_res", res, 32'h0);
    chk("midrst_flags", {27'b0, flags}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("midrst_no_result", seen, 0);
    run_op(32'h40C00000, 32'h40400000, lat, r, f);
    chk("post_rst_lat", lat, 28);
    chk("post_rst_res", r, 32'h40000000);
    chk("post_rst_flags", {27'b0, f}, 32'd0);
    finish_op();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
